// File: rtl/axil_uart_tx_responder.sv
`default_nettype none
// ============================================================================
// Module   : axil_uart_tx_responder
// Purpose  : AXI4-Lite responder for the UART register window. Provides a
//            TXDATA/STATUS/CTRL/DIV register map, a TX byte FIFO and an 8N1
//            serial transmitter with a programmable bit period.
// Ports    : chipset_clk / chipset_rst  - clock, synchronous active-high reset
//            uart_axi_aw* / w* / b*     - AXI4-Lite write address/data/response
//            uart_axi_ar* / r*          - AXI4-Lite read address/data
//            uart_tx                    - serial output, idles high
//            uart_irq                   - level interrupt, transmitter drained
// Revision : 1.0 - initial release
// ============================================================================
module axil_uart_tx_responder #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        chipset_clk,
  input  logic        chipset_rst,
  input  logic [12:0] uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic [3:0]  uart_axi_wstrb,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  input  logic [12:0] uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  output logic        uart_tx,
  output logic        uart_irq
);

  localparam int unsigned        c_ptr_w       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned        c_cnt_w       = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth       = c_cnt_w'(FIFO_DEPTH);
  localparam logic [1:0]         c_resp_okay   = 2'b00;
  localparam logic [1:0]         c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  logic [1:0]         r_ctrl;
  logic [15:0]        r_div;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  tx_state_t          r_state, w_state_next;
  logic [7:0]         r_shift, w_shift_next;
  logic [2:0]         r_bit_idx, w_bit_idx_next;
  logic [15:0]        r_baud, w_baud_next;
  logic               r_tx, w_tx_next;
  logic               r_irq;
  logic               r_bvalid, r_rvalid;
  logic [1:0]         r_bresp, r_rresp;
  logic [31:0]        r_rdata;

  logic        w_full, w_empty, w_busy, w_pop, w_push;
  logic        w_wr_fire, w_rd_fire, w_aw_err, w_ar_err, w_txdata_wr, w_bit_done;
  logic [15:0] w_bit_len;
  logic [31:0] w_status, w_rd_word;
  logic        w_unused_ok;

  assign w_unused_ok = ^{uart_axi_wdata[31:16], uart_axi_wstrb[3:2],
                         uart_axi_awaddr[1:0], uart_axi_araddr[1:0]};

  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != ST_IDLE);
  // A programmed period of zero would never terminate a bit; run it as one.
  assign w_bit_len  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_done = (r_baud == 16'd0);

  // Address and data are accepted together in a single combinational pulse;
  // the outstanding response blocks further writes until it is consumed.
  assign w_wr_fire   = ~chipset_rst & uart_axi_awvalid & uart_axi_wvalid & ~r_bvalid;
  assign w_rd_fire   = ~chipset_rst & uart_axi_arvalid & ~r_rvalid;
  assign w_aw_err    = |uart_axi_awaddr[12:4];
  assign w_ar_err    = |uart_axi_araddr[12:4];
  assign w_txdata_wr = w_wr_fire & ~w_aw_err & (uart_axi_awaddr[3:2] == 2'd0) & uart_axi_wstrb[0];
  assign w_pop       = (r_state == ST_IDLE) & r_ctrl[0] & ~w_empty;
  // A simultaneous pop frees a slot first, so a push into a full FIFO succeeds.
  assign w_push      = w_txdata_wr & (~w_full | w_pop);

  assign uart_axi_awready = w_wr_fire;
  assign uart_axi_wready  = w_wr_fire;
  assign uart_axi_bvalid  = r_bvalid;
  assign uart_axi_bresp   = r_bresp;
  assign uart_axi_arready = w_rd_fire;
  assign uart_axi_rvalid  = r_rvalid;
  assign uart_axi_rresp   = r_rresp;
  assign uart_axi_rdata   = r_rdata;
  assign uart_tx          = r_tx;
  assign uart_irq         = r_irq;

  // Write channel and writable registers
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      r_ctrl   <= 2'b00;
      r_div    <= DEFAULT_DIV;
      r_bvalid <= 1'b0;
      r_bresp  <= c_resp_okay;
    end else begin
      if (r_bvalid && uart_axi_bready) r_bvalid <= 1'b0;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= c_resp_okay;
        if (w_aw_err) begin
          r_bresp <= c_resp_slverr;
        end else begin
          case (uart_axi_awaddr[3:2])
            2'd0: if (uart_axi_wstrb[0] && !w_push) r_bresp <= c_resp_slverr;
            2'd2: if (uart_axi_wstrb[0]) r_ctrl <= uart_axi_wdata[1:0];
            2'd3: begin
              if (uart_axi_wstrb[0]) r_div[7:0]  <= uart_axi_wdata[7:0];
              if (uart_axi_wstrb[1]) r_div[15:8] <= uart_axi_wdata[15:8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read channel: data captured from pre-edge state
  always_comb begin
    w_status               = '0;
    w_status[0]            = w_full;
    w_status[1]            = w_empty;
    w_status[2]            = w_busy;
    w_status[4 +: c_cnt_w] = r_count;
  end

  always_comb begin
    w_rd_word = '0;
    case (uart_axi_araddr[3:2])
      2'd1:    w_rd_word = w_status;
      2'd2:    w_rd_word = {30'd0, r_ctrl};
      2'd3:    w_rd_word = {16'd0, r_div};
      default: w_rd_word = '0;
    endcase
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= c_resp_okay;
      r_rdata  <= '0;
    end else begin
      if (r_rvalid && uart_axi_rready) r_rvalid <= 1'b0;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_ar_err ? c_resp_slverr : c_resp_okay;
        r_rdata  <= w_ar_err ? 32'd0 : w_rd_word;
      end
    end
  end

  // TX FIFO
  always_ff @(posedge chipset_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= uart_axi_wdata[7:0];
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // TX FSM: r_baud counts down the remaining cycles of the current bit and is
  // reloaded at every bit boundary, so DIV changes apply from the next bit.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_baud_next    = r_baud;
    w_tx_next      = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (w_pop) begin
          w_shift_next   = r_mem[r_rd_ptr];
          w_bit_idx_next = 3'd0;
          w_baud_next    = w_bit_len - 16'd1;
          w_tx_next      = 1'b0;
          w_state_next   = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_baud_next  = w_bit_len - 16'd1;
          w_tx_next    = r_shift[0];
          w_state_next = ST_DATA;
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_baud_next = w_bit_len - 16'd1;
          if (r_bit_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          w_tx_next    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_baud_next = r_baud - 16'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_baud    <= 16'd0;
      r_tx      <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_baud    <= w_baud_next;
      r_tx      <= w_tx_next;
      r_irq     <= r_ctrl[1] & w_empty & (r_state == ST_IDLE);
    end
  end

endmodule
`default_nettype wire
